// File: rtl/shift_request_arbiter.sv
// Purpose : shares one combinational left shifter between NREQ requesters;
//           round-robin grant, registered shifter operands, valid/ready result.
// Latency : grant in cycle N, rsp_valid from cycle N+2; at least 3 cycles per result.
// Backpressure: while rsp_valid is held (rsp_ready=0) no request is granted.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is a one-hot grant, only in IDLE
//   req_a/req_shift      packed operands, requester i at [i*WIDTH +: WIDTH]
//   sh_a/sh_shift        registered operands to the shared shifter
//   sh_y                 result from the shared shifter
//   rsp_valid/rsp_ready  result handshake
//   rsp_y/rsp_id         result and the index of the requester that owns it
//
// Build option: define SHIFT_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest asserted index always wins. Without it, arbitration is round-robin.
module shift_request_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_shift,
  output logic [WIDTH-1:0]      sh_a,
  output logic [WIDTH-1:0]      sh_shift,
  input  logic [WIDTH-1:0]      sh_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [IDW-1:0]        rsp_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_shift_q, sh_shift_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  // Round-robin pointer: index of the requester with top priority next time.
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  // Winner search: scan base, base+1, ... wrapping at NREQ; first valid wins.
  // Fixed priority is the same scan with the base pinned at 0, so no pointer
  // exists in that build.
  always_comb begin
    int base;
    int k;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    k         = 0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    base      = 0;
`else
    base      = int'(ptr_q);
`endif
    for (int i = 0; i < NREQ; i++) begin
      k = base + i;
      if (k >= NREQ) k = k - NREQ;
      if (!gnt_found && req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(k);
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    int nxt;
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_shift_d  = sh_shift_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    nxt         = int'(rsp_id_q) + 1;
    if (nxt >= NREQ) nxt = 0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          sh_a_d             = req_a[gnt_idx*WIDTH +: WIDTH];
          sh_shift_d         = req_shift[gnt_idx*WIDTH +: WIDTH];
          rsp_id_d           = gnt_idx;
          state_d            = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Shifter inputs have been stable for a full cycle; capture its result.
        rsp_y_d     = sh_y;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
          // The requester just served drops to lowest priority.
          ptr_d       = IDW'(nxt);
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_a_q      <= '0;
      sh_shift_q  <= '0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_shift_q  <= sh_shift_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign sh_a      = sh_a_q;
  assign sh_shift  = sh_shift_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_shift_request_arbiter.sv
// Directed bench for shift_request_arbiter (WIDTH=4, NREQ=2) with a
// behavioural logical left shifter closing the sh_* loop.
module tb_shift_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_shift;
  logic [3:0] sh_a;
  logic [3:0] sh_shift;
  logic [3:0] sh_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_y;
  logic [0:0] rsp_id;

  int checks = 0;
  int errors = 0;
  logic [1:0] rdy_s;

  always #5 clk = ~clk;

  // Shared shifter: shifts of WIDTH or more give zero.
  assign sh_y = (sh_shift >= 4'd4) ? 4'd0 : (sh_a << sh_shift);

  shift_request_arbiter #(.WIDTH(4), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_shift (req_shift),
    .sh_a      (sh_a),
    .sh_shift  (sh_shift),
    .sh_y      (sh_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: grants are sampled at the falling edge, the granted requester
  // withdraws just after the rising edge, then outputs are left to settle.
  task automatic tick();
    @(negedge clk);
    rdy_s = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rdy_s;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Single requester transaction with the consumer ready once the result shows.
  task automatic txn(input int idx, input logic [3:0] a, input logic [3:0] s,
                     input logic [3:0] exp_y, input string tag);
    req_a[idx*4 +: 4]     = a;
    req_shift[idx*4 +: 4] = s;
    req_valid             = 2'b00;
    req_valid[idx]        = 1'b1;
    rsp_ready             = 1'b0;
    #1;
    check({tag, "_ready"}, req_ready, 32'(1 << idx));
    tick();
    tick();
    check({tag, "_vld"}, rsp_valid, 1);
    check({tag, "_y"}, rsp_y, exp_y);
    check({tag, "_id"}, rsp_id, idx);
    rsp_ready = 1'b1;
    tick();
    check({tag, "_done"}, rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [0:0] exp_id;
    req_a     = '0;
    req_shift = '0;
    do_reset();

    // Reset state
    check("rst_vld", rsp_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_y", rsp_y, 0);
    check("rst_id", rsp_id, 0);
    check("rst_sh_a", sh_a, 0);
    check("rst_sh_shift", sh_shift, 0);

    // 1: lone request, grant same cycle, result two cycles later
    req_a[3:0] = 4'b0101; req_shift[3:0] = 4'd1;
    req_valid = 2'b01;
    #1;
    check("t1_ready", req_ready, 2'b01);
    tick();
    check("t1_shift_vld", rsp_valid, 0);
    check("t1_sh_a", sh_a, 4'b0101);
    check("t1_sh_shift", sh_shift, 1);
    check("t1_ready_busy", req_ready, 0);
    tick();
    check("t1_vld", rsp_valid, 1);
    check("t1_y", rsp_y, 4'b1010);
    check("t1_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    check("t1_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // 2: both request together from reset
    do_reset();
    req_a = {4'b0011, 4'b1111}; req_shift = {4'd2, 4'd1};
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    check("t2_ready0", req_ready, 2'b01);
    tick(); tick();
    check("t2_vld0", rsp_valid, 1);
    check("t2_y0", rsp_y, 4'b1110);
    check("t2_id0", rsp_id, 0);
    tick();
    check("t2_ready1", req_ready, 2'b10);
    tick(); tick();
    check("t2_vld1", rsp_valid, 1);
    check("t2_y1", rsp_y, 4'b1100);
    check("t2_id1", rsp_id, 1);
    tick();

    // 3: consumer stalls 5 cycles in RESP while req1 waits
    rsp_ready = 1'b0;
    req_a[3:0] = 4'b0110; req_shift[3:0] = 4'd1;
    req_valid = 2'b01;
    tick();
    req_a[7:4] = 4'b0001; req_shift[7:4] = 4'd3;
    req_valid[1] = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_vld", rsp_valid, 1);
      check("t3_stall_y", rsp_y, 4'b1100);
      check("t3_stall_id", rsp_id, 0);
      check("t3_stall_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    check("t3_hs_ready", req_ready, 0);
    tick();
    check("t3_idle_vld", rsp_valid, 0);
    check("t3_req1_ready", req_ready, 2'b10);
    tick(); tick();
    check("t3_y1", rsp_y, 4'b1000);
    check("t3_id1", rsp_id, 1);
    tick();

    // 4: shift boundaries (shift == WIDTH and shift == 0)
    do_reset();
    txn(0, 4'b1111, 4'd4, 4'b0000, "t4_sh4");
    txn(1, 4'b1011, 4'd0, 4'b1011, "t4_sh0");

    // 5: reset while in SHIFT drops the transaction
    req_a[3:0] = 4'b0101; req_shift[3:0] = 4'd2;
    req_valid = 2'b01;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", rsp_valid, 0);
    check("t5_rst_sh_a", sh_a, 0);
    repeat (2) begin
      tick();
      check("t5_no_rsp", rsp_valid, 0);
    end
    rst_n = 1'b1;
    req_a = {4'b0001, 4'b0001}; req_shift = {4'd2, 4'd1};
    req_valid = 2'b11;
    #1;
    check("t5_ready0", req_ready, 2'b01);
    tick(); tick();
    check("t5_y0", rsp_y, 4'b0010);
    check("t5_id0", rsp_id, 0);
    rsp_ready = 1'b1;
    tick(); tick(); tick();
    check("t5_y1", rsp_y, 4'b0100);
    check("t5_id1", rsp_id, 1);
    tick();

    // 6: both held high for four transactions
    do_reset();
    req_a = {4'b0010, 4'b0001}; req_shift = {4'd0, 4'd0};
    for (int t = 0; t < 4; t++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = 1'(t % 2);
`endif
      rsp_ready = 1'b0;
      req_valid = 2'b11;
      tick();
      req_valid = 2'b11;
      tick();
      check("t6_vld", rsp_valid, 1);
      check("t6_id", rsp_id, exp_id);
      check("t6_y", rsp_y, (exp_id == 1'b0) ? 4'b0001 : 4'b0010);
      rsp_ready = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
